// File: rtl/mips_pkg.sv
// Shared MIPS definitions: ALUOp and funct encodings, ALU operation enum,
// forwarding select codes and the ALU-control decode helper.
package mips_pkg;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_ORI   = 2'b11;

  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_NOR = 6'b100111;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;

  localparam logic [1:0] FWD_REG  = 2'b00;
  localparam logic [1:0] FWD_WB   = 2'b01;
  localparam logic [1:0] FWD_MEM  = 2'b10;
  localparam logic [1:0] FWD_REG2 = 2'b11;

  // ALU_NONE covers unknown R-type functs and forces a zero result.
  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_NOR,
    ALU_SLT,
    ALU_NONE
  } alu_op_t;

  function automatic alu_op_t alu_decode(input logic [1:0] aluop, input logic [5:0] funct);
    alu_op_t op;
    op = ALU_NONE;
    case (aluop)
      ALUOP_ADD: op = ALU_ADD;
      ALUOP_SUB: op = ALU_SUB;
      ALUOP_ORI: op = ALU_OR;
      default: begin
        case (funct)
          FUNCT_ADD: op = ALU_ADD;
          FUNCT_SUB: op = ALU_SUB;
          FUNCT_AND: op = ALU_AND;
          FUNCT_OR:  op = ALU_OR;
          FUNCT_NOR: op = ALU_NOR;
          FUNCT_SLT: op = ALU_SLT;
          default:   op = ALU_NONE;
        endcase
      end
    endcase
    return op;
  endfunction

endpackage

// File: rtl/alu_mips.sv
// Combinational MIPS ALU: (a, b, op) -> (result, zero). Add/sub wrap, SLT is a
// true signed compare.
module alu_mips
  import mips_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  alu_op_t           op,
  output logic [DATA_W-1:0] result,
  output logic              zero
);

  always_comb begin
    // NOTE: default assignment first so no path through the case infers a latch.
    result = '0;
    case (op)
      ALU_ADD: result = a + b;
      ALU_SUB: result = a - b;
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_NOR: result = ~(a | b);
      ALU_SLT: result = {{(DATA_W-1){1'b0}}, ($signed(a) < $signed(b))};
      default: result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/ex_stage_mem.sv
// MIPS execute stage plus EX/MEM pipeline register with stall (hold) and flush (bubble).
// Optional operand forwarding is enabled by defining FORWARDING_EN.
module ex_stage_mem
  import mips_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic              reg_escribir_EX,
  input  logic              mem_a_reg_EX,
  input  logic              mem_escribir_EX,
  input  logic              mem_leer_EX,
  input  logic              branch_EX,
  input  logic              alu_fuente_EX,
  input  logic [1:0]        alu_operacion_EX,
  input  logic [DATA_W-1:0] pc_plus4_EX,
  input  logic [DATA_W-1:0] dr1_EX,
  input  logic [DATA_W-1:0] dr2_EX,
  input  logic [DATA_W-1:0] inmediato_ext_EX,
  input  logic [REG_AW-1:0] rt_EX,
  input  logic [REG_AW-1:0] rd_EX,
  input  logic [5:0]        funct_EX,
  input  logic [1:0]        fwd_a_sel,
  input  logic [1:0]        fwd_b_sel,
  input  logic [DATA_W-1:0] wb_data_WB,
  output logic              reg_escribir_MEM,
  output logic              mem_a_reg_MEM,
  output logic              mem_escribir_MEM,
  output logic              mem_leer_MEM,
  output logic              pcsrc_MEM,
  output logic [DATA_W-1:0] branch_target_MEM,
  output logic [DATA_W-1:0] alu_result_MEM,
  output logic              zero_MEM,
  output logic [DATA_W-1:0] dato_escribir_MEM,
  output logic [REG_AW-1:0] reg_destino_MEM
);

  logic [DATA_W-1:0] w_op_a;
  logic [DATA_W-1:0] w_b_reg;
  logic [DATA_W-1:0] w_op_b;
  logic [DATA_W-1:0] w_alu_result;
  logic              w_alu_zero;
  logic [DATA_W-1:0] w_branch_target;
  logic [REG_AW-1:0] w_reg_destino;
  alu_op_t           w_alu_op;

`ifdef FORWARDING_EN
  // Select 10 feeds back our own EX/MEM result register.
  always_comb begin
    w_op_a = dr1_EX;
    case (fwd_a_sel)
      FWD_WB:  w_op_a = wb_data_WB;
      FWD_MEM: w_op_a = alu_result_MEM;
      default: w_op_a = dr1_EX;
    endcase
  end

  always_comb begin
    w_b_reg = dr2_EX;
    case (fwd_b_sel)
      FWD_WB:  w_b_reg = wb_data_WB;
      FWD_MEM: w_b_reg = alu_result_MEM;
      default: w_b_reg = dr2_EX;
    endcase
  end
`else
  wire w_unused_fwd = ^{fwd_a_sel, fwd_b_sel, wb_data_WB};
  assign w_op_a  = dr1_EX;
  assign w_b_reg = dr2_EX;
`endif

  assign w_op_b          = alu_fuente_EX ? inmediato_ext_EX : w_b_reg;
  assign w_alu_op        = alu_decode(alu_operacion_EX, funct_EX);
  assign w_branch_target = pc_plus4_EX + {inmediato_ext_EX[DATA_W-3:0], 2'b00};
  assign w_reg_destino   = (alu_operacion_EX == ALUOP_RTYPE) ? rd_EX : rt_EX;

  alu_mips #(.DATA_W(DATA_W)) u_alu (
    .a      (w_op_a),
    .b      (w_op_b),
    .op     (w_alu_op),
    .result (w_alu_result),
    .zero   (w_alu_zero)
  );

  // Priority: reset > flush > stall > load; a flush always produces an all-zero bubble.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      reg_escribir_MEM  <= 1'b0;
      mem_a_reg_MEM     <= 1'b0;
      mem_escribir_MEM  <= 1'b0;
      mem_leer_MEM      <= 1'b0;
      pcsrc_MEM         <= 1'b0;
      branch_target_MEM <= '0;
      alu_result_MEM    <= '0;
      zero_MEM          <= 1'b0;
      dato_escribir_MEM <= '0;
      reg_destino_MEM   <= '0;
    end else if (flush) begin
      reg_escribir_MEM  <= 1'b0;
      mem_a_reg_MEM     <= 1'b0;
      mem_escribir_MEM  <= 1'b0;
      mem_leer_MEM      <= 1'b0;
      pcsrc_MEM         <= 1'b0;
      branch_target_MEM <= '0;
      alu_result_MEM    <= '0;
      zero_MEM          <= 1'b0;
      dato_escribir_MEM <= '0;
      reg_destino_MEM   <= '0;
    end else if (!stall) begin
      reg_escribir_MEM  <= reg_escribir_EX;
      mem_a_reg_MEM     <= mem_a_reg_EX;
      mem_escribir_MEM  <= mem_escribir_EX;
      mem_leer_MEM      <= mem_leer_EX;
      pcsrc_MEM         <= branch_EX & w_alu_zero;
      branch_target_MEM <= w_branch_target;
      alu_result_MEM    <= w_alu_result;
      zero_MEM          <= w_alu_zero;
      dato_escribir_MEM <= w_b_reg;
      reg_destino_MEM   <= w_reg_destino;
    end
  end

endmodule

// File: tb/tb_ex_stage_mem.sv
// Self-checking bench for ex_stage_mem: directed cases then randomized traffic
// against a behavioural EX/MEM model (forwarding cases only when FORWARDING_EN is defined).
module tb_ex_stage_mem;

  localparam int DW = 32;
  localparam int AW = 5;

  typedef struct {
    logic        rw, m2r, mw, mr, br, src;
    logic [1:0]  aluop;
    logic [31:0] pc, dr1, dr2, imm;
    logic [4:0]  rt, rd;
    logic [5:0]  funct;
    logic [1:0]  fa, fb;
    logic [31:0] wb;
  } ex_in_t;

  typedef struct {
    logic        rw, m2r, mw, mr, pcsrc, zero;
    logic [31:0] target, result, store;
    logic [4:0]  dest;
  } ex_out_t;

  logic clk = 1'b0;
  logic reset, stall, flush;
  logic reg_escribir_EX, mem_a_reg_EX, mem_escribir_EX, mem_leer_EX, branch_EX, alu_fuente_EX;
  logic [1:0]    alu_operacion_EX, fwd_a_sel, fwd_b_sel;
  logic [DW-1:0] pc_plus4_EX, dr1_EX, dr2_EX, inmediato_ext_EX, wb_data_WB;
  logic [AW-1:0] rt_EX, rd_EX;
  logic [5:0]    funct_EX;
  logic reg_escribir_MEM, mem_a_reg_MEM, mem_escribir_MEM, mem_leer_MEM, pcsrc_MEM, zero_MEM;
  logic [DW-1:0] branch_target_MEM, alu_result_MEM, dato_escribir_MEM;
  logic [AW-1:0] reg_destino_MEM;

  int checks = 0;
  int errors = 0;
  ex_out_t exp_q;

  always #5 clk = ~clk;

  ex_stage_mem #(.DATA_W(DW), .REG_AW(AW)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .reg_escribir_EX(reg_escribir_EX), .mem_a_reg_EX(mem_a_reg_EX),
    .mem_escribir_EX(mem_escribir_EX), .mem_leer_EX(mem_leer_EX),
    .branch_EX(branch_EX), .alu_fuente_EX(alu_fuente_EX),
    .alu_operacion_EX(alu_operacion_EX), .pc_plus4_EX(pc_plus4_EX),
    .dr1_EX(dr1_EX), .dr2_EX(dr2_EX), .inmediato_ext_EX(inmediato_ext_EX),
    .rt_EX(rt_EX), .rd_EX(rd_EX), .funct_EX(funct_EX),
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .wb_data_WB(wb_data_WB),
    .reg_escribir_MEM(reg_escribir_MEM), .mem_a_reg_MEM(mem_a_reg_MEM),
    .mem_escribir_MEM(mem_escribir_MEM), .mem_leer_MEM(mem_leer_MEM),
    .pcsrc_MEM(pcsrc_MEM), .branch_target_MEM(branch_target_MEM),
    .alu_result_MEM(alu_result_MEM), .zero_MEM(zero_MEM),
    .dato_escribir_MEM(dato_escribir_MEM), .reg_destino_MEM(reg_destino_MEM)
  );

  function automatic ex_out_t zero_out();
    ex_out_t o;
    o.rw = 0; o.m2r = 0; o.mw = 0; o.mr = 0; o.pcsrc = 0; o.zero = 0;
    o.target = 0; o.result = 0; o.store = 0; o.dest = 0;
    return o;
  endfunction

  // Reference: what an EX stage should produce for one instruction, from the ISA rules.
  function automatic ex_out_t model(input ex_in_t x, input logic [31:0] prev_result);
    ex_out_t o;
    logic [31:0] a, breg, b, r;
    a = x.dr1;
    breg = x.dr2;
`ifdef FORWARDING_EN
    if (x.fa == 2'b01) a = x.wb;
    else if (x.fa == 2'b10) a = prev_result;
    if (x.fb == 2'b01) breg = x.wb;
    else if (x.fb == 2'b10) breg = prev_result;
`else
    if (prev_result === 32'hx) a = 0;
`endif
    b = x.src ? x.imm : breg;
    r = 0;
    if (x.aluop == 2'b00) r = a + b;
    else if (x.aluop == 2'b01) r = a - b;
    else if (x.aluop == 2'b11) r = a | b;
    else if (x.funct == 6'd32) r = a + b;
    else if (x.funct == 6'd34) r = a - b;
    else if (x.funct == 6'd36) r = a & b;
    else if (x.funct == 6'd37) r = a | b;
    else if (x.funct == 6'd39) r = ~(a | b);
    else if (x.funct == 6'd42) r = (int'(a) < int'(b)) ? 1 : 0;
    o.rw = x.rw; o.m2r = x.m2r; o.mw = x.mw; o.mr = x.mr;
    o.result = r;
    o.zero = (r == 0);
    o.pcsrc = x.br && (r == 0);
    o.target = x.pc + x.imm * 4;
    o.store = breg;
    o.dest = (x.aluop == 2'b10) ? x.rd : x.rt;
    return o;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".rw"},     32'(reg_escribir_MEM),  32'(exp_q.rw));
    chk({tag, ".m2r"},    32'(mem_a_reg_MEM),     32'(exp_q.m2r));
    chk({tag, ".mw"},     32'(mem_escribir_MEM),  32'(exp_q.mw));
    chk({tag, ".mr"},     32'(mem_leer_MEM),      32'(exp_q.mr));
    chk({tag, ".pcsrc"},  32'(pcsrc_MEM),         32'(exp_q.pcsrc));
    chk({tag, ".zero"},   32'(zero_MEM),          32'(exp_q.zero));
    chk({tag, ".target"}, branch_target_MEM,      exp_q.target);
    chk({tag, ".result"}, alu_result_MEM,         exp_q.result);
    chk({tag, ".store"},  dato_escribir_MEM,      exp_q.store);
    chk({tag, ".dest"},   32'(reg_destino_MEM),   32'(exp_q.dest));
  endtask

  task automatic drive(input ex_in_t x, input logic st, input logic fl);
    stall = st; flush = fl;
    reg_escribir_EX = x.rw; mem_a_reg_EX = x.m2r; mem_escribir_EX = x.mw; mem_leer_EX = x.mr;
    branch_EX = x.br; alu_fuente_EX = x.src; alu_operacion_EX = x.aluop;
    pc_plus4_EX = x.pc; dr1_EX = x.dr1; dr2_EX = x.dr2; inmediato_ext_EX = x.imm;
    rt_EX = x.rt; rd_EX = x.rd; funct_EX = x.funct;
    fwd_a_sel = x.fa; fwd_b_sel = x.fb; wb_data_WB = x.wb;
  endtask

  // Drive after the falling edge, clock once, update the model, then compare on the next falling edge.
  task automatic step(input string tag, input ex_in_t x, input logic st, input logic fl);
    drive(x, st, fl);
    @(posedge clk);
    if (fl) exp_q = zero_out();
    else if (!st) exp_q = model(x, exp_q.result);
    @(negedge clk);
    check_all(tag);
  endtask

  function automatic ex_in_t blank();
    ex_in_t x;
    x.rw = 0; x.m2r = 0; x.mw = 0; x.mr = 0; x.br = 0; x.src = 0; x.aluop = 0;
    x.pc = 0; x.dr1 = 0; x.dr2 = 0; x.imm = 0; x.rt = 0; x.rd = 0; x.funct = 0;
    x.fa = 0; x.fb = 0; x.wb = 0;
    return x;
  endfunction

  function automatic ex_in_t rand_in();
    ex_in_t x;
    logic [5:0] functs [7];
    functs = '{6'd32, 6'd34, 6'd36, 6'd37, 6'd39, 6'd42, 6'd0};
    x = blank();
    x.rw = 1'($urandom); x.m2r = 1'($urandom); x.mw = 1'($urandom); x.mr = 1'($urandom);
    x.br = 1'($urandom); x.src = 1'($urandom); x.aluop = 2'($urandom);
    x.pc = $urandom; x.imm = $urandom; x.wb = $urandom;
    x.dr1 = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
    x.dr2 = ($urandom_range(0, 3) == 0) ? x.dr1 : $urandom;
    x.rt = 5'($urandom); x.rd = 5'($urandom);
    x.funct = ($urandom_range(0, 7) == 7) ? 6'($urandom) : functs[$urandom_range(0, 5)];
    x.fa = 2'($urandom); x.fb = 2'($urandom);
    return x;
  endfunction

  initial begin
    ex_in_t x;
    ex_out_t held;
    reset = 1'b1;
    drive(blank(), 1'b0, 1'b0);
    exp_q = zero_out();
    #2;
    check_all("reset");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // R-type add 5 + 7 into rd=3
    x = blank(); x.rw = 1; x.aluop = 2'b10; x.funct = 6'b100000; x.dr1 = 5; x.dr2 = 7; x.rd = 3; x.rt = 9;
    step("radd", x, 0, 0);
    chk("radd.result_const", alu_result_MEM, 32'd12);
    chk("radd.dest_const", 32'(reg_destino_MEM), 32'd3);

    // Taken beq with negative offset
    x = blank(); x.br = 1; x.aluop = 2'b01; x.dr1 = 9; x.dr2 = 9; x.pc = 32'h100; x.imm = 32'hFFFF_FFFF;
    step("beq", x, 0, 0);
    chk("beq.pcsrc_const", 32'(pcsrc_MEM), 32'd1);
    chk("beq.target_const", branch_target_MEM, 32'h0000_00FC);

    // Signed SLT both ways
    x = blank(); x.aluop = 2'b10; x.funct = 6'b101010; x.dr1 = 32'hFFFF_FFFF; x.dr2 = 1;
    step("slt_neg", x, 0, 0);
    chk("slt_neg.const", alu_result_MEM, 32'd1);
    x.dr1 = 1; x.dr2 = 32'hFFFF_FFFF;
    step("slt_pos", x, 0, 0);
    chk("slt_pos.const", alu_result_MEM, 32'd0);

    // lw address calc, then three stalled cycles with different inputs
    x = blank(); x.rw = 1; x.m2r = 1; x.mr = 1; x.src = 1; x.aluop = 2'b00;
    x.dr1 = 32'h1000; x.imm = 8; x.rt = 17; x.rd = 4;
    step("lw", x, 0, 0);
    chk("lw.result_const", alu_result_MEM, 32'h1008);
    chk("lw.dest_const", 32'(reg_destino_MEM), 32'd17);
    held = exp_q;
    for (int i = 0; i < 3; i++) begin
      step($sformatf("stall%0d", i), rand_in(), 1, 0);
      chk($sformatf("stall%0d.result_held", i), alu_result_MEM, held.result);
    end

    // Flush together with stall on a store still bubbles
    x = rand_in(); x.mw = 1; x.rw = 1;
    step("flush_stall", x, 1, 1);
    chk("flush_stall.mw_const", 32'(mem_escribir_MEM), 32'd0);

    // Reload, then reset asynchronously between edges
    step("preload", rand_in(), 0, 0);
    #2 reset = 1'b1;
    #1;
    exp_q = zero_out();
    check_all("async_reset");
    @(negedge clk);
    check_all("reset_held");
    reset = 1'b0;

`ifdef FORWARDING_EN
    x = blank(); x.aluop = 2'b10; x.funct = 6'b100000; x.dr1 = 5; x.dr2 = 7;
    step("fwd_seed", x, 0, 0);
    x = blank(); x.aluop = 2'b10; x.funct = 6'b100010; x.fa = 2'b10; x.dr1 = 32'hDEAD; x.dr2 = 3;
    step("fwd_mem", x, 0, 0);
    chk("fwd_mem.const", alu_result_MEM, 32'd9);
    x = blank(); x.aluop = 2'b10; x.funct = 6'b100000; x.fb = 2'b01; x.wb = 4; x.dr1 = 1; x.dr2 = 32'hBEEF;
    step("fwd_wb", x, 0, 0);
    chk("fwd_wb.const", alu_result_MEM, 32'd5);
    chk("fwd_wb.store_const", dato_escribir_MEM, 32'd4);
`endif

    // Randomized traffic with occasional stall/flush
    for (int i = 0; i < 300; i++) begin
      step($sformatf("rnd%0d", i), rand_in(), ($urandom_range(0, 6) == 0), ($urandom_range(0, 9) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
